// File: rtl/mem_map_pkg.sv
// Shared definitions for the memory subsystem: MMIO address map, UART status
// layout, TX FSM encoding and read-source selection.
package mem_map_pkg;

    localparam logic [15:0] UART_DATA = 16'hFFF0;
    localparam logic [15:0] UART_STAT = 16'hFFF1;
    localparam logic [15:0] CYC_LO    = 16'hFFF2;
    localparam logic [15:0] CYC_HI    = 16'hFFF3;

    localparam int unsigned STAT_FULL      = 0;
    localparam int unsigned STAT_BUSY      = 1;
    localparam int unsigned STAT_OVF       = 2;
    localparam int unsigned STAT_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    // Where a read port's registered output comes from in the following cycle.
    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_RAM  = 2'd1,
        SRC_MMIO = 2'd2
    } read_src_e;

    function automatic logic [15:0] stat_word(input logic       full,
                                              input logic       busy,
                                              input logic       ovf,
                                              input logic [7:0] count);
        logic [15:0] w;
        w                          = '0;
        w[STAT_FULL]               = full;
        w[STAT_BUSY]               = busy;
        w[STAT_OVF]                = ovf;
        w[STAT_COUNT_LSB +: 8]     = count;
        return w;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 serial transmitter (LSB first, one start and one
// stop bit, each bit held CLKS_PER_BIT cycles).
module uart_tx_fifo
    import mem_map_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 16,
    localparam int unsigned PTR_W       = $clog2(FIFO_DEPTH),
    localparam int unsigned CNT_W       = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [7:0]       data,
    output logic             full,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             drop,
    output logic             tx
);

    localparam int unsigned       BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_e         state, state_n;
    logic [BAUD_W-1:0] baud, baud_n;
    logic [2:0]        bit_idx, bit_idx_n;
    logic [7:0]        shift, shift_n;
    logic              tx_n;
    logic              pop;
    logic              accept;

    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;

    assign full   = (count == CNT_W'(FIFO_DEPTH));
    assign busy   = (state != IDLE);
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;

    // NOTE: the storage array is deliberately not reset; the pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (accept) fifo_mem[wr_ptr] <= data;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
            case ({accept, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
            tx      <= tx_n;
        end
    end

    // NOTE: every signal driven here is given a default first, so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_n   = state;
        baud_n    = baud;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        pop       = 1'b0;
        tx_n      = 1'b1;

        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop     = 1'b1;
                    shift_n = fifo_mem[rd_ptr];
                    baud_n  = '0;
                    state_n = START;
                end
            end
            START: begin
                if (baud == BAUD_LAST) begin
                    baud_n    = '0;
                    bit_idx_n = '0;
                    state_n   = DATA;
                end else begin
                    baud_n = baud + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud == BAUD_LAST) begin
                    baud_n  = '0;
                    shift_n = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) state_n = STOP;
                    else                 bit_idx_n = bit_idx + 3'd1;
                end else begin
                    baud_n = baud + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud == BAUD_LAST) begin
                    baud_n  = '0;
                    state_n = IDLE;
                end else begin
                    baud_n = baud + BAUD_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // The line is registered from the next state so it switches with the FSM.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            default: tx_n = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_bus.sv
// Memory subsystem behind the CPU: unified RAM with two registered read ports
// and one write port, plus an MMIO window for the UART and cycle counter.
module mem_bus
    import mem_map_pkg::*;
#(
    parameter int unsigned RAM_WORDS    = 16384,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_en,
    input  logic [15:0] mem_read0_addr,
    output logic [15:0] mem_read0_data,
    input  logic [15:0] mem_read1_addr,
    output logic [15:0] mem_read1_data,
    input  logic        mem_write_en,
    input  logic [15:0] mem_write_addr,
    input  logic [15:0] mem_write_data,
    output logic        uart_tx
);

    localparam int unsigned RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

    function automatic logic in_ram(input logic [15:0] addr);
        return 32'(addr) < RAM_WORDS;
    endfunction

    logic [15:0]      ram [RAM_WORDS];
    logic [15:0]      ram_q0, ram_q1;
    logic [15:0]      mmio_q1, mmio_val1;
    read_src_e        src0, src1;

    logic [31:0]      cyc_count;
    logic [15:0]      cyc_hi_latch;
    logic             overflow;

    logic             ram_we;
    logic             uart_push, uart_full, uart_busy, uart_drop;
    logic [CNT_W-1:0] uart_count;
    logic             stat_rd, lo_rd;

    assign ram_we    = mem_write_en && in_ram(mem_write_addr);
    assign uart_push = mem_write_en && (mem_write_addr == UART_DATA);
    // MMIO side effects are triggered only by the data-side port.
    assign stat_rd   = mem_read_en && (mem_read1_addr == UART_STAT);
    assign lo_rd     = mem_read_en && (mem_read1_addr == CYC_LO);

    uart_tx_fifo #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .FIFO_DEPTH   (FIFO_DEPTH)
    ) u_uart (
        .clk   (clk),
        .rst   (rst),
        .push  (uart_push),
        .data  (mem_write_data[7:0]),
        .full  (uart_full),
        .count (uart_count),
        .busy  (uart_busy),
        .drop  (uart_drop),
        .tx    (uart_tx)
    );

    // Read-first: both reads sample the array before this edge's write lands.
    always_ff @(posedge clk) begin
        if (ram_we) ram[mem_write_addr[RAM_AW-1:0]] <= mem_write_data;
        if (mem_read_en) begin
            ram_q0 <= ram[mem_read0_addr[RAM_AW-1:0]];
            ram_q1 <= ram[mem_read1_addr[RAM_AW-1:0]];
        end
    end

    always_comb begin
        mmio_val1 = '0;
        case (mem_read1_addr)
            UART_STAT: mmio_val1 = stat_word(uart_full, uart_busy, overflow, 8'(uart_count));
            CYC_LO:    mmio_val1 = cyc_count[15:0];
            CYC_HI:    mmio_val1 = cyc_hi_latch;
            default:   mmio_val1 = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src0         <= SRC_ZERO;
            src1         <= SRC_ZERO;
            mmio_q1      <= '0;
            cyc_count    <= '0;
            cyc_hi_latch <= '0;
            overflow     <= 1'b0;
        end else begin
            cyc_count <= cyc_count + 32'd1;
            if (mem_read_en) begin
                src0    <= in_ram(mem_read0_addr) ? SRC_RAM : SRC_ZERO;
                src1    <= in_ram(mem_read1_addr) ? SRC_RAM : SRC_MMIO;
                mmio_q1 <= mmio_val1;
            end
            if (lo_rd) cyc_hi_latch <= cyc_count[31:16];
            if (uart_drop)    overflow <= 1'b1;
            else if (stat_rd) overflow <= 1'b0;
        end
    end

    always_comb begin
        mem_read0_data = (src0 == SRC_RAM) ? ram_q0 : '0;
        case (src1)
            SRC_RAM:  mem_read1_data = ram_q1;
            SRC_MMIO: mem_read1_data = mmio_q1;
            default:  mem_read1_data = '0;
        endcase
    end

endmodule

// File: tb/tb_mem_bus.sv
// Directed bench for mem_bus: RAM ports, MMIO decode, UART framing/FIFO and
// the cycle counter latch, with a serial receiver collecting transmitted bytes.
module tb_mem_bus;

    localparam int unsigned CPB        = 4;
    localparam int unsigned DEPTH      = 4;
    localparam int unsigned WORDS      = 1024;
    localparam logic [15:0] A_DATA     = 16'hFFF0;
    localparam logic [15:0] A_STAT     = 16'hFFF1;
    localparam logic [15:0] A_LO       = 16'hFFF2;
    localparam logic [15:0] A_HI       = 16'hFFF3;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_en;
    logic [15:0] mem_read0_addr, mem_read0_data;
    logic [15:0] mem_read1_addr, mem_read1_data;
    logic        mem_write_en;
    logic [15:0] mem_write_addr, mem_write_data;
    logic        uart_tx;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] tb_cyc;
    logic [7:0]  rx_q[$];
    logic        rx_busy = 1'b0;
    int          rx_t    = 0;
    int          rx_ferr = 0;
    logic [7:0]  rx_sh   = '0;

    mem_bus #(
        .RAM_WORDS    (WORDS),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_read_en    (mem_read_en),
        .mem_read0_addr (mem_read0_addr),
        .mem_read0_data (mem_read0_data),
        .mem_read1_addr (mem_read1_addr),
        .mem_read1_data (mem_read1_data),
        .mem_write_en   (mem_write_en),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data),
        .uart_tx        (uart_tx)
    );

    always #5 clk = ~clk;

    // Reference cycle count: zero under reset, +1 on every other edge.
    always @(posedge clk) begin
        if (rst) tb_cyc <= '0;
        else     tb_cyc <= tb_cyc + 32'd1;
    end

    // Serial receiver sampling mid-bit, starting from the first low cycle.
    always @(negedge clk) begin
        if (rst) begin
            rx_busy = 1'b0;
        end else if (!rx_busy) begin
            if (uart_tx == 1'b0) begin
                rx_busy = 1'b1;
                rx_t    = 0;
            end
        end else begin
            rx_t++;
            if (rx_t >= CPB && rx_t < 9 * CPB && (rx_t % CPB) == CPB / 2)
                rx_sh = {uart_tx, rx_sh[7:1]};
            if (rx_t == 9 * CPB + CPB / 2) begin
                if (uart_tx !== 1'b1) rx_ferr++;
                rx_q.push_back(rx_sh);
                rx_busy = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input logic [15:0] addr, input logic [15:0] data);
        mem_write_en   = 1'b1;
        mem_write_addr = addr;
        mem_write_data = data;
        tick();
        mem_write_en   = 1'b0;
    endtask

    task automatic rd0(input logic [15:0] addr, output logic [15:0] data);
        mem_read0_addr = addr;
        mem_read_en    = 1'b1;
        tick();
        data           = mem_read0_data;
        mem_read_en    = 1'b0;
    endtask

    task automatic rd1(input logic [15:0] addr, output logic [15:0] data);
        mem_read1_addr = addr;
        mem_read_en    = 1'b1;
        tick();
        data           = mem_read1_data;
        mem_read_en    = 1'b0;
    endtask

    function automatic logic [39:0] frame_bits(input logic [7:0] b);
        logic [39:0] f;
        for (int c = 0; c < 40; c++) begin
            if (c < 4)       f[c] = 1'b0;
            else if (c >= 36) f[c] = 1'b1;
            else             f[c] = b[(c - 4) / 4];
        end
        return f;
    endfunction

    initial begin
        logic [15:0] d;
        logic [31:0] exp_cyc;
        logic [39:0] frame;
        logic        busy_all;
        logic        low_seen;
        logic [7:0]  b;

        rst            = 1'b1;
        mem_read_en    = 1'b0;
        mem_read0_addr = '0;
        mem_read1_addr = '0;
        mem_write_en   = 1'b0;
        mem_write_addr = '0;
        mem_write_data = '0;
        repeat (3) tick();
        check("rst_rd0", mem_read0_data, 16'h0000);
        check("rst_rd1", mem_read1_data, 16'h0000);
        check("rst_tx", uart_tx, 1'b1);
        rst = 1'b0;
        rd1(A_STAT, d);
        check("rst_stat", d, 16'h0000);

        // RAM read-first collision
        wr(16'h0010, 16'hBEEF);
        mem_write_en   = 1'b1;
        mem_write_addr = 16'h0010;
        mem_write_data = 16'h1234;
        mem_read1_addr = 16'h0010;
        mem_read_en    = 1'b1;
        tick();
        mem_write_en = 1'b0;
        mem_read_en  = 1'b0;
        check("collide_old", mem_read1_data, 16'hBEEF);
        rd1(16'h0010, d);
        check("collide_new", d, 16'h1234);
        rd0(16'h0010, d);
        check("rd0_agrees", d, 16'h1234);

        // Latency and hold
        wr(16'h0020, 16'h5A5A);
        mem_read0_addr = 16'h0020;
        mem_read_en    = 1'b1;
        check("lat_before_edge", mem_read0_data, 16'h1234);
        tick();
        check("lat_one_cycle", mem_read0_data, 16'h5A5A);
        mem_read_en    = 1'b0;
        mem_read0_addr = 16'h0010;
        wr(16'h0020, 16'hFFFF);
        repeat (2) tick();
        check("hold_no_en", mem_read0_data, 16'h5A5A);

        // Address map boundaries
        wr(16'h0000, 16'h1111);
        wr(16'h03FF, 16'h7777);
        wr(16'h0400, 16'h8888);
        rd1(16'h03FF, d);
        check("ram_last_word", d, 16'h7777);
        rd1(16'h0400, d);
        check("unmapped_above_ram", d, 16'h0000);
        rd1(16'h0000, d);
        check("no_alias_write", d, 16'h1111);
        rd0(16'h0400, d);
        check("rd0_unmapped", d, 16'h0000);
        rd1(16'hFFF4, d);
        check("unmapped_mmio", d, 16'h0000);
        rd1(A_DATA, d);
        check("uart_data_reads_0", d, 16'h0000);
        rd0(A_LO, d);
        check("rd0_cyc_lo_zero", d, 16'h0000);

        // Live counter from reset
        exp_cyc = tb_cyc;
        rd1(A_LO, d);
        check("cyc_lo_live", d, exp_cyc[15:0]);
        rd1(A_HI, d);
        check("cyc_hi_live", d, 16'h0000);

        // Single frame 0xA5
        rx_q.delete();
        wr(A_DATA, 16'h00A5);
        check("pop_cycle_tx", uart_tx, 1'b1);
        mem_read1_addr = A_STAT;
        mem_read_en    = 1'b1;
        busy_all       = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            frame[i] = uart_tx;
            if (i >= 1) busy_all &= mem_read1_data[1];
        end
        mem_read_en = 1'b0;
        check("frame_a5", frame, frame_bits(8'hA5));
        check("busy_in_frame", busy_all, 1'b1);
        tick();
        rd1(A_STAT, d);
        check("stat_after_frame", d, 16'h0000);
        check("rx_a5_count", rx_q.size(), 1);
        b = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
        check("rx_a5", b, 8'hA5);

        // Overflow: six writes into a depth-4 FIFO
        rx_q.delete();
        for (int i = 0; i < 6; i++) wr(A_DATA, 16'h0041 + 16'(i));
        rd1(A_STAT, d);
        check("ovf_stat", d, 16'h0407);
        rd1(A_STAT, d);
        check("ovf_cleared", d, 16'h0403);
        for (int i = 0; i < 400 && rx_q.size() < 5; i++) tick();
        repeat (60) tick();
        check("ovf_rx_count", rx_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            b = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            check($sformatf("ovf_rx_%0d", i), b, 8'h41 + 8'(i));
        end
        rd1(A_STAT, d);
        check("ovf_drained", d, 16'h0000);

        // Push into a full FIFO on the exact cycle IDLE pops
        rx_q.delete();
        for (int i = 0; i < 5; i++) wr(A_DATA, 16'h0050 + 16'(i));
        repeat (37) tick();
        wr(A_DATA, 16'h0055);
        rd1(A_STAT, d);
        check("full_push_pop_stat", d, 16'h0403);
        for (int i = 0; i < 500 && rx_q.size() < 6; i++) tick();
        repeat (60) tick();
        check("full_push_pop_count", rx_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            b = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            check($sformatf("full_push_pop_rx_%0d", i), b, 8'h50 + 8'(i));
        end
        check("rx_framing", rx_ferr, 0);

        // High-half latch with the counter forced near a 16-bit carry
        force dut.cyc_count = 32'h0001FFFF;
        rd1(A_LO, d);
        check("forced_lo", d, 16'hFFFF);
        force dut.cyc_count = 32'h00020005;
        rd1(A_HI, d);
        check("hi_is_latched", d, 16'h0001);
        rd0(A_LO, d);
        check("rd0_lo_forced", d, 16'h0000);
        rd1(A_HI, d);
        check("rd0_no_latch", d, 16'h0001);
        rd1(A_LO, d);
        check("forced_lo2", d, 16'h0005);
        rd1(A_HI, d);
        check("hi_relatched", d, 16'h0002);
        release dut.cyc_count;

        // Reset during DATA bit 3 with two bytes queued
        for (int i = 0; i < 3; i++) wr(A_DATA, 16'h0061 + 16'(i));
        repeat (16) tick();
        check("bit3_low_before_rst", uart_tx, 1'b0);
        rst = 1'b1;
        tick();
        check("rst_mid_frame_tx", uart_tx, 1'b1);
        tick();
        rst = 1'b0;
        rx_q.delete();
        rd1(A_STAT, d);
        check("rst_mid_frame_stat", d, 16'h0000);
        low_seen = 1'b0;
        repeat (100) begin
            tick();
            if (uart_tx !== 1'b1) low_seen = 1'b1;
        end
        check("no_frame_after_rst", low_seen, 1'b0);
        check("no_rx_after_rst", rx_q.size(), 0);
        exp_cyc = tb_cyc;
        rd1(A_LO, d);
        check("cyc_lo_after_rst", d, exp_cyc[15:0]);
        rd1(A_HI, d);
        check("cyc_hi_after_rst", d, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
